// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
//   Bundles the write, alloc and read buses of the multi-port register file.
//   master : producer side (decode / writeback / operand fetch)
//   slave  : the register file itself
//   Signals:
//     i_we        per-port write enable           (N_WPORTS)
//     i_waddr     per-port write address, packed  (N_WPORTS*AW)
//     i_wdata     per-port write data, packed     (N_WPORTS*XLEN)
//     i_alloc     mark a destination busy
//     i_alloc_addr register to mark busy          (AW)
//     i_raddr     per-port read address, packed   (N_RPORTS*AW)
//     o_rdata     per-port read data, packed      (N_RPORTS*XLEN)
//     o_rbusy     busy flag of each read address  (N_RPORTS)
//     o_busy_vec  full scoreboard                 (N_REGS)
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int N_REGS   = 32,
  parameter int XLEN     = 32,
  parameter int N_WPORTS = 2,
  parameter int N_RPORTS = 2
);
  localparam int AW = $clog2(N_REGS);

  logic [N_WPORTS-1:0]      i_we;
  logic [N_WPORTS*AW-1:0]   i_waddr;
  logic [N_WPORTS*XLEN-1:0] i_wdata;
  logic                     i_alloc;
  logic [AW-1:0]            i_alloc_addr;
  logic [N_RPORTS*AW-1:0]   i_raddr;
  logic [N_RPORTS*XLEN-1:0] o_rdata;
  logic [N_RPORTS-1:0]      o_rbusy;
  logic [N_REGS-1:0]        o_busy_vec;

  modport master (
    output i_we, i_waddr, i_wdata, i_alloc, i_alloc_addr, i_raddr,
    input  o_rdata, o_rbusy, o_busy_vec
  );

  modport slave (
    input  i_we, i_waddr, i_wdata, i_alloc, i_alloc_addr, i_raddr,
    output o_rdata, o_rbusy, o_busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-port integer register file with a per-register busy scoreboard.
//   - N_WPORTS write ports; on an address conflict the highest-index port wins.
//   - N_RPORTS asynchronous read ports.
//   - Register 0 is hardwired to zero and is never busy.
//   - Alloc sets busy, a write clears it; alloc beats a same-cycle write.
//   Ports:
//     i_clk  clock, all state updates on the rising edge
//     i_rst  synchronous active-high reset (clears data and scoreboard)
//     bus    regfile_mp_if.slave (write/alloc/read buses, see interface)
//   Build option:
//     REGFILE_BYPASS_EN  same-cycle write-to-read forwarding; when undefined
//                        reads see only stored data and stored busy bits.
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int N_REGS   = 32,
  parameter int XLEN     = 32,
  parameter int N_WPORTS = 2,
  parameter int N_RPORTS = 2
) (
  input logic         i_clk,
  input logic         i_rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(N_REGS);

  logic [XLEN-1:0]   regs [N_REGS];
  logic [N_REGS-1:0] busy;

  // One-hot write select per port; bit 0 is never set, which is what keeps
  // register 0 at zero and never busy.
  logic [N_REGS-1:0] wsel [N_WPORTS];
  logic [N_REGS-1:0] wclr;
  logic [N_REGS-1:0] aset;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value held (no latch is inferred).
  always_comb begin
    wclr = '0;
    for (int p = 0; p < N_WPORTS; p++) begin
      wsel[p] = '0;
      if (bus.i_we[p] && (bus.i_waddr[p*AW +: AW] != '0))
        wsel[p][bus.i_waddr[p*AW +: AW]] = 1'b1;
      wclr = wclr | wsel[p];
    end
    aset = '0;
    if (bus.i_alloc && (bus.i_alloc_addr != '0))
      aset[bus.i_alloc_addr] = 1'b1;
  end

  // NOTE: the storage array is reset on purpose: architectural state must read
  // 0 after reset, so every entry is cleared rather than left uninitialised.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      // Ports are visited in ascending order, so the last non-blocking
      // assignment to a register (highest-index port) is the one that lands.
      for (int i = 1; i < N_REGS; i++) begin
        for (int p = 0; p < N_WPORTS; p++) begin
          if (wsel[p][i]) regs[i] <= bus.i_wdata[p*XLEN +: XLEN];
        end
      end
      // Alloc is applied after the clear: a new producer supersedes the
      // write that is retiring in the same cycle.
      busy <= (busy & ~wclr) | aset;
    end
  end

  for (genvar r = 0; r < N_RPORTS; r++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign ra = bus.i_raddr[r*AW +: AW];

    always_comb begin
      data = regs[ra];
      bsy  = busy[ra];
      if (ra == '0) begin
        data = '0;
        bsy  = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      // Forward in-flight write data; the register is no longer waiting on a
      // producer unless a new one is allocated in this same cycle.
      for (int p = 0; p < N_WPORTS; p++) begin
        if (wsel[p][ra]) begin
          data = bus.i_wdata[p*XLEN +: XLEN];
          bsy  = aset[ra];
        end
      end
      if (i_rst) begin
        data = '0;
        bsy  = 1'b0;
      end
`endif
    end

    assign bus.o_rdata[r*XLEN +: XLEN] = data;
    assign bus.o_rbusy[r]              = bsy;
  end

  assign bus.o_busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int N_REGS = 32;
  localparam int XLEN   = 32;
  localparam int NW     = 2;
  localparam int NR     = 2;
  localparam int AW     = $clog2(N_REGS);

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  regfile_mp_if #(.N_REGS(N_REGS), .XLEN(XLEN), .N_WPORTS(NW), .N_RPORTS(NR)) ifc ();

  regfile_mp #(.N_REGS(N_REGS), .XLEN(XLEN), .N_WPORTS(NW), .N_RPORTS(NR)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (ifc.slave)
  );

  // Stimulus state owned by the bench
  logic            rst;
  logic            w_en   [NW];
  logic [AW-1:0]   w_addr [NW];
  logic [XLEN-1:0] w_data [NW];
  logic            al_en;
  logic [AW-1:0]   al_addr;
  logic [AW-1:0]   r_addr [NR];

  // Reference model: architectural register contents and busy flags
  logic [XLEN-1:0] m_regs [N_REGS];
  logic            m_busy [N_REGS];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    i_rst = rst;
    for (int p = 0; p < NW; p++) begin
      ifc.i_we[p]                  = w_en[p];
      ifc.i_waddr[p*AW +: AW]      = w_addr[p];
      ifc.i_wdata[p*XLEN +: XLEN]  = w_data[p];
    end
    ifc.i_alloc      = al_en;
    ifc.i_alloc_addr = al_addr;
    for (int r = 0; r < NR; r++) ifc.i_raddr[r*AW +: AW] = r_addr[r];
  endtask

  task automatic idle();
    rst = 1'b0;
    for (int p = 0; p < NW; p++) begin
      w_en[p] = 1'b0; w_addr[p] = '0; w_data[p] = '0;
    end
    al_en = 1'b0; al_addr = '0;
  endtask

  // Clock edge: the model takes the architectural update, then inputs go idle.
  task automatic tick();
    @(posedge i_clk);
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        m_regs[i] = '0; m_busy[i] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (w_en[p] && w_addr[p] != 0) begin
          m_regs[w_addr[p]] = w_data[p];
          m_busy[w_addr[p]] = 1'b0;
        end
      end
      if (al_en && al_addr != 0) m_busy[al_addr] = 1'b1;
    end
    @(negedge i_clk);
    idle();
    apply();
  endtask

  // Expected value of one read port given the model and current inputs.
  task automatic exp_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
    d = m_regs[a];
    b = m_busy[a];
    if (a == 0) begin d = '0; b = 1'b0; end
`ifdef REGFILE_BYPASS_EN
    if (rst) begin
      d = '0; b = 1'b0;
    end else if (a != 0) begin
      for (int p = 0; p < NW; p++) begin
        if (w_en[p] && w_addr[p] == a) begin
          d = w_data[p];
          b = al_en && (al_addr == a);
        end
      end
    end
`endif
  endtask

  task automatic check_reads(input string tag);
    logic [XLEN-1:0] d;
    logic            b;
    logic [N_REGS-1:0] bv;
    for (int r = 0; r < NR; r++) begin
      exp_read(r_addr[r], d, b);
      check($sformatf("%s_rdata%0d_a%0d", tag, r, r_addr[r]), ifc.o_rdata[r*XLEN +: XLEN], d);
      check($sformatf("%s_rbusy%0d_a%0d", tag, r, r_addr[r]), {31'b0, ifc.o_rbusy[r]}, {31'b0, b});
    end
    for (int i = 0; i < N_REGS; i++) bv[i] = m_busy[i];
    check({tag, "_busy_vec"}, ifc.o_busy_vec, bv);
  endtask

  task automatic set_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    r_addr[0] = a0;
    r_addr[1] = a1;
    apply();
    #1;
  endtask

  initial begin
    for (int i = 0; i < N_REGS; i++) begin
      m_regs[i] = '0; m_busy[i] = 1'b0;
    end
    idle();
    r_addr[0] = '0; r_addr[1] = '0;
    apply();

    // Reset, then sweep every address on both ports
    rst = 1'b1; apply(); tick();
    for (int a = 0; a < N_REGS; a++) begin
      set_read(AW'(a), AW'(N_REGS - 1 - a));
      check_reads("after_rst");
    end
    check("rst_busy_vec_zero", ifc.o_busy_vec, '0);

    // Port0 writes r5; both ports see it next cycle
    w_en[0] = 1'b1; w_addr[0] = 5; w_data[0] = 32'hDEADBEEF; apply(); tick();
    set_read(5, 5);
    check("r5_p0", ifc.o_rdata[0 +: XLEN], 32'hDEADBEEF);
    check("r5_p1", ifc.o_rdata[XLEN +: XLEN], 32'hDEADBEEF);
    check_reads("r5");

    // Write to r0 is ignored
    w_en[0] = 1'b1; w_addr[0] = 0; w_data[0] = 32'h11; apply(); tick();
    set_read(0, 0);
    check("r0_zero", ifc.o_rdata[0 +: XLEN], 32'h0);

    // Same-register conflict: port1 wins
    w_en[0] = 1'b1; w_addr[0] = 7; w_data[0] = 32'hAAAA;
    w_en[1] = 1'b1; w_addr[1] = 7; w_data[1] = 32'hBBBB; apply(); tick();
    set_read(7, 5);
    check("r7_conflict", ifc.o_rdata[0 +: XLEN], 32'hBBBB);
    check_reads("r7");

    // Alloc r3 -> busy next cycle
    al_en = 1'b1; al_addr = 3; apply(); tick();
    set_read(3, 0);
    check("r3_busy", {31'b0, ifc.o_rbusy[0]}, 32'h1);
    check("r3_busy_vec", {31'b0, ifc.o_busy_vec[3]}, 32'h1);

    // Port1 write to busy r3 clears busy and commits data
    w_en[1] = 1'b1; w_addr[1] = 3; w_data[1] = 32'h42; apply(); tick();
    set_read(3, 3);
    check("r3_cleared", {31'b0, ifc.o_busy_vec[3]}, 32'h0);
    check("r3_data", ifc.o_rdata[XLEN +: XLEN], 32'h42);

    // Alloc and write r9 together: alloc wins, data commits
    al_en = 1'b1; al_addr = 9; w_en[0] = 1'b1; w_addr[0] = 9; w_data[0] = 32'h5; apply(); tick();
    set_read(9, 9);
    check("r9_busy", {31'b0, ifc.o_busy_vec[9]}, 32'h1);
    check("r9_data", ifc.o_rdata[0 +: XLEN], 32'h5);

    // Alloc r0 is ignored
    al_en = 1'b1; al_addr = 0; apply(); tick();
    set_read(0, 9);
    check("r0_not_busy", {31'b0, ifc.o_busy_vec[0]}, 32'h0);
    check("r0_rbusy", {31'b0, ifc.o_rbusy[0]}, 32'h0);

    // Reset beats a same-cycle alloc and write
    al_en = 1'b1; al_addr = 4; w_en[0] = 1'b1; w_addr[0] = 4; w_data[0] = 32'h77; rst = 1'b1;
    r_addr[0] = 4; apply(); #1;
    check_reads("rst_cycle");
    tick();
    set_read(4, 9);
    check("r4_after_rst", ifc.o_rdata[0 +: XLEN], 32'h0);
    check("r4_busy_after_rst", {31'b0, ifc.o_busy_vec[4]}, 32'h0);
    check("r9_wiped", ifc.o_rdata[XLEN +: XLEN], 32'h0);

    // Same-cycle write/read of r6: forwarded with bypass, old value without
    w_en[0] = 1'b1; w_addr[0] = 6; w_data[0] = 32'h55; apply(); tick();
    w_en[0] = 1'b1; w_addr[0] = 6; w_data[0] = 32'h1234;
    set_read(6, 6);
`ifdef REGFILE_BYPASS_EN
    check("r6_bypass", ifc.o_rdata[0 +: XLEN], 32'h1234);
`else
    check("r6_old", ifc.o_rdata[0 +: XLEN], 32'h55);
`endif
    tick();
    set_read(6, 6);
    check("r6_next", ifc.o_rdata[XLEN +: XLEN], 32'h1234);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NW; p++) begin
        w_en[p]   = ($urandom_range(0, 3) != 0);
        w_addr[p] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        w_data[p] = $urandom;
      end
      al_en   = ($urandom_range(0, 2) == 0);
      al_addr = ($urandom_range(0, 1) != 0) ? w_addr[$urandom_range(0, NW-1)] : AW'($urandom_range(0, 7));
      rst     = ($urandom_range(0, 49) == 0);
      for (int r = 0; r < NR; r++)
        r_addr[r] = ($urandom_range(0, 1) != 0) ? w_addr[$urandom_range(0, NW-1)] : AW'($urandom_range(0, 7));
      apply(); #1;
      check_reads("rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single write-port decoder path.
- Has N_WPORTS write ports with a fixed priority, N_RPORTS asynchronous read ports, a hardwired-zero register 0, and a per-register busy scoreboard for in-flight writes.
- Sits in the core register stage. Decode drives the alloc port. Writeback drives the write ports. Operand fetch drives the read ports.

Parameters:
- N_REGS, 32: number of architectural registers (power of two, ≥2).
- XLEN, 32: register data width.
- N_WPORTS, 2: number of write ports (≥1).
- N_RPORTS, 2: number of read ports (≥1).

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_we  in  N_WPORTS  per-port write enable.
- i_waddr  in  N_WPORTS*$clog2(N_REGS)  per-port write address, port p at slice p.
- i_wdata  in  N_WPORTS*XLEN  per-port write data.
- i_alloc  in  1  mark a destination register busy.
- i_alloc_addr  in  $clog2(N_REGS)  register to mark busy.
- i_raddr  in  N_RPORTS*$clog2(N_REGS)  per-port read address.
- o_rdata  out  N_RPORTS*XLEN  per-port read data.
- o_rbusy  out  N_RPORTS  busy flag of the addressed register.
- o_busy_vec  out  N_REGS  full scoreboard.

Behaviour:
- Reset (i_rst=1 at the clock edge): all registers become 0 and all busy bits become 0.
  - Reset has priority over every write and alloc in the same cycle.
  - Reset mid-operation discards in-flight writes; no partial update.
  - After reset: o_rdata=0, o_rbusy=0, o_busy_vec=0.
- Register 0:
  - Always reads 0, with busy always 0.
  - Writes and allocs to address 0 are ignored.
  - Per-port enable is gated as i_we[p] && waddr_p!=0, via one-hot decode per port.
- Write:
  - Takes effect on the clock edge; visible to reads in the next cycle, except with the bypass feature.
- Write conflict:
  - If several enabled ports target the same register in one cycle, the highest-index port wins.
  - The losing data is dropped with no error.
  - Non-conflicting ports all commit in the same cycle.
- Scoreboard:
  - An enabled write (any port, addr≠0) clears busy[addr] at the edge.
  - i_alloc with addr≠0 sets busy[addr] at the edge.
  - Alloc and write to the same register in the same cycle: alloc wins, so busy stays 1 (the new producer supersedes).
  - Alloc of an already-busy register: stays 1.
  - Write to a non-busy register: busy stays 0; the data still commits.
- Read:
  - Purely combinational from i_raddr.
  - o_rbusy[r] = busy[raddr_r]; o_busy_vec is the registered busy array.
  - Reads of the same address on several ports return identical data.
- Latency:
  - Write to read: 1 cycle.
  - Alloc to busy visible: 1 cycle.
  - Write to busy clear: 1 cycle.
- Out-of-range: none possible, because N_REGS is a power of two.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - Write-to-read forwarding in the same cycle.
  - If any enabled write port targets raddr_r (≠0), o_rdata[r] returns that port's data, highest-index port first.
  - o_rbusy[r] reads 0 for that register unless an alloc to it occurs in the same cycle.
  - Never forwards while i_rst=1; outputs 0/0 in that case.
- Not defined:
  - Reads return the stored value and the stored busy bit only.
  - Written data appears one cycle later.

Test Plan:
- Reset then read all addresses -> o_rdata=0 and o_rbusy=0 on every port; o_busy_vec=0.
- Port0 writes 0xDEADBEEF to r5; next cycle read r5 on both ports -> 0xDEADBEEF on each.
- Port0 writes 0x11 to r0 -> r0 still reads 0.
- Port0 writes 0xAAAA and port1 writes 0xBBBB to r7 in the same cycle -> r7=0xBBBB.
- Alloc r3 -> busy[3]=1 next cycle.
- With r3 busy, port1 writes 0x42 to r3 -> busy[3]=0 and data 0x42.
- In one cycle alloc r9 and write r9=0x5 -> busy[9]=1 and data 0x5.
- Alloc r0 -> busy stays 0.
- Alloc r4 and write r4=0x77, with i_rst=1 in that cycle -> r4=0 and busy[4]=0.
- With REGFILE_BYPASS_EN, write r6=0x1234 while reading r6 in the same cycle -> o_rdata=0x1234 combinationally.
- Without REGFILE_BYPASS_EN, the same stimulus -> old value, then 0x1234 next cycle.
